select_disp_scan: RTL and testbench

//  Digit-select scanner for an 8-position multiplexed 7-segment display.

---
 rtl/select_disp_scan.sv | 87 ++++++++
 tb/tb_select_disp_scan.sv | 110 +++++++++++
 2 files changed

// File: rtl/select_disp_scan.sv
// Purpose : digit-select scanner for a multiplexed 7-segment display; one select active at a time, blank gap per slot.
// Latency : out is registered and lags the slot counters by one cycle; first active select on the 3rd edge after reset (defaults).
// Backpressure: none; free-running scan, no handshake.
//
// Ports:
//   clk   - system clock, all state changes on the rising edge
//   rst_n - asynchronous active-low reset; forces out to all-inactive immediately
//   out   - registered digit-select vector, out[i] drives digit i
module select_disp_scan #(
  parameter int DIV          = 100,  // clock cycles per digit slot
  parameter int BLANK_CYCLES = 2,    // all-inactive cycles at the start of each slot
  parameter int NUM_DIGITS   = 8,    // positions scanned, 0..NUM_DIGITS-1
  parameter bit ACTIVE_LOW   = 1'b1  // polarity of the selected bit
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] out
);

  // Guarded so an illegal DIV still elaborates far enough to reach the error below.
  localparam int CW = (DIV >= 2) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [2:0]    IDX_LAST = 3'(NUM_DIGITS - 1);
  localparam logic [7:0]    IDLE     = ACTIVE_LOW ? 8'hFF : 8'h00;

  // Elaboration-time parameter legality.
  if (DIV < 2) begin : g_bad_div
    $error("select_disp_scan: DIV must be >= 2");
  end
  if (BLANK_CYCLES < 0 || BLANK_CYCLES >= DIV) begin : g_bad_blank
    $error("select_disp_scan: BLANK_CYCLES must satisfy 0 <= BLANK_CYCLES < DIV");
  end
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("select_disp_scan: NUM_DIGITS must be in 1..8");
  end

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic          in_blank;
  logic [7:0]    sel_oh;
  logic [7:0]    out_nxt;

  // With no blanking the comparison would be against zero and constant-false,
  // so it is dropped outright rather than left to the tools.
  if (BLANK_CYCLES == 0) begin : g_no_blank
    assign in_blank = 1'b0;
  end else begin : g_blank
    localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYCLES);
    assign in_blank = (cnt < BLANK_C);
  end

  // Next select value from the pre-edge counters. idx never exceeds
  // NUM_DIGITS-1, so unused upper bits stay inactive by construction.
  always_comb begin
    sel_oh  = 8'h01 << idx;
    out_nxt = IDLE;
    if (!in_blank) begin
      out_nxt = ACTIVE_LOW ? ~sel_oh : sel_oh;
    end
  end

  // Slot counter and digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Output register; the blank at cnt==0 guarantees the old and new digit
  // never overlap on a slot change when BLANK_CYCLES > 0, and with no blank
  // the one-hot value simply moves to the next bit on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= IDLE;
    end else begin
      out <= out_nxt;
    end
  end

endmodule

// File: tb/tb_select_disp_scan.sv
// Purpose : randomized-reset bench for select_disp_scan, four parameter sets compared to a scan model.
// Latency : model is evaluated from the count of clock edges since reset release.
// Backpressure: not applicable.
`timescale 1ns/1ps
module tb_select_disp_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] out_def, out_n4, out_nb, out_n1;

  int vectors = 0;
  int miscompares = 0;
  int n_edges = 0;   // rising edges seen with rst_n high since the last reset

  always #5 clk = ~clk;

  // Defaults: DIV=100, BLANK=2, 8 digits, active low.
  select_disp_scan u_def (.clk(clk), .rst_n(rst_n), .out(out_def));

  // Four digits, active high, short slot.
  select_disp_scan #(.DIV(10), .BLANK_CYCLES(2), .NUM_DIGITS(4), .ACTIVE_LOW(1'b0))
    u_n4 (.clk(clk), .rst_n(rst_n), .out(out_n4));

  // No blanking, minimum slot length.
  select_disp_scan #(.DIV(2), .BLANK_CYCLES(0), .NUM_DIGITS(8), .ACTIVE_LOW(1'b1))
    u_nb (.clk(clk), .rst_n(rst_n), .out(out_nb));

  // Single digit: toggles blank/active every slot.
  select_disp_scan #(.DIV(5), .BLANK_CYCLES(1), .NUM_DIGITS(1), .ACTIVE_LOW(1'b1))
    u_n1 (.clk(clk), .rst_n(rst_n), .out(out_n1));

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Expected select after n edges: edge k shows the slot state that held
  // during cycle k-1, i.e. position (k-1) cycles into the scan.
  function automatic logic [7:0] model(input int n, input int div, input int blank,
                                       input int nd, input bit al);
    logic [7:0] idle;
    logic [7:0] sel;
    int c;
    int i;
    idle = al ? 8'hFF : 8'h00;
    if (n == 0) return idle;
    c = (n - 1) % div;
    i = ((n - 1) / div) % nd;
    if (c < blank) return idle;
    sel = 8'h01 << i;
    return al ? ~sel : sel;
  endfunction

  function automatic logic [7:0] n_active(input logic [7:0] v, input bit al);
    return 8'($countones(al ? ~v : v));
  endfunction

  task automatic chk_all_idle(input string tag);
    chk({tag, "_def"}, out_def, 8'hFF);
    chk({tag, "_n4"},  out_n4,  8'h00);
    chk({tag, "_nb"},  out_nb,  8'hFF);
    chk({tag, "_n1"},  out_n1,  8'hFF);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n_edges <= 0;
    else        n_edges <= n_edges + 1;
  end

  // Every cycle, away from the rising edge.
  always @(negedge clk) begin
    chk("def", out_def, model(n_edges, 100, 2, 8, 1'b1));
    chk("n4",  out_n4,  model(n_edges, 10, 2, 4, 1'b0));
    chk("nb",  out_nb,  model(n_edges, 2, 0, 8, 1'b1));
    chk("n1",  out_n1,  model(n_edges, 5, 1, 1, 1'b1));
    if (n_active(out_def, 1'b1) > 8'd1) chk("onehot_def", n_active(out_def, 1'b1), 8'd1);
    if (n_active(out_n4, 1'b0) > 8'd1)  chk("onehot_n4",  n_active(out_n4, 1'b0), 8'd1);
    if (n_active(out_nb, 1'b1) > 8'd1)  chk("onehot_nb",  n_active(out_nb, 1'b1), 8'd1);
    chk("upper_n4", {4'h0, out_n4[7:4]}, 8'h00);
    chk("upper_n1", {1'b0, out_n1[7:1]}, 8'h7F);
  end

  initial begin
    // Reset asserted before any clock edge must already force idle.
    #1 rst_n = 1'b0;
    #1 chk_all_idle("rst_pre_edge");
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b1;

    // Long uninterrupted run: more than one full 800-cycle default scan.
    repeat (1200) @(posedge clk);

    // Random mid-slot resets with random hold and run lengths.
    for (int k = 0; k < 5; k++) begin
      #($urandom_range(1, 3)) rst_n = 1'b0;
      #1 chk_all_idle("rst_async");
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #($urandom_range(1, 3)) rst_n = 1'b1;
      repeat ($urandom_range(100, 900)) @(posedge clk);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
